bf16_norm_sched: RTL

//  Shares one normalisation unit (lzc tree + left shifter + exponent adjust) between N_REQ

---
 rtl/bf16_norm_sched.sv | 90 +++++++++
 1 files changed

// File: rtl/bf16_norm_sched.sv
// bf16_norm_sched: round-robin shared 2-stage normaliser (lzc, left shift, exponent adjust)
module bf16_norm_sched #(
  parameter int N_REQ = 2,
  parameter int MW = 16,
  parameter int EW = 8,
  localparam int IDW = $clog2(N_REQ),
  localparam int CW = $clog2(MW + 1)
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [N_REQ-1:0]    req_valid_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic [N_REQ-1:0]    req_sign_i,
  input  logic [N_REQ*EW-1:0] req_exp_i,
  input  logic [N_REQ*MW-1:0] req_mant_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [IDW-1:0]     res_id_o,
  output logic               res_sign_o,
  output logic [EW-1:0]      res_exp_o,
  output logic [MW-1:0]      res_mant_o,
  output logic               res_zero_o,
  output logic               res_uflow_o
);
  logic [IDW-1:0] ptr, gnt_id, scan;
  logic gnt_any, s1_en, s2_en, xfer;
  logic s1_valid, s1_sign;
  logic [IDW-1:0] s1_id;
  logic [EW-1:0] s1_exp;
  logic [MW-1:0] s1_mant;
  logic [CW-1:0] cnt;
  logic zero, uflow;
  assign s2_en = ~res_valid_o | res_ready_i;
  assign s1_en = ~s1_valid | s2_en;
  // descending scan so the earliest position after ptr overwrites last
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    scan = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan = IDW'((int'(ptr) + k) % N_REQ);
      gnt_any = req_valid_i[scan] ? 1'b1 : gnt_any;
      gnt_id = req_valid_i[scan] ? scan : gnt_id;
    end
  end
  assign xfer = nreset & gnt_any & s1_en;
  assign req_ready_o = xfer ? (N_REQ'(1) << gnt_id) : '0;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ptr <= '0;
      s1_valid <= 1'b0;
      s1_id <= '0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_mant <= '0;
    end else if (s1_en) begin
      ptr <= xfer ? ((gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1)) : ptr;
      s1_valid <= xfer;
      s1_id <= gnt_id;
      s1_sign <= req_sign_i[gnt_id];
      s1_exp <= req_exp_i[gnt_id*EW +: EW];
      s1_mant <= req_mant_i[gnt_id*MW +: MW];
    end
  end
  always_comb begin
    cnt = CW'(MW);
    for (int i = 0; i < MW; i++) cnt = s1_mant[i] ? CW'(MW - 1 - i) : cnt;
  end
  assign zero = s1_mant == '0;
  assign uflow = {1'b0, s1_exp} <= (EW + 1)'(cnt);
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      res_valid_o <= 1'b0;
      res_id_o <= '0;
      res_sign_o <= 1'b0;
      res_exp_o <= '0;
      res_mant_o <= '0;
      res_zero_o <= 1'b0;
      res_uflow_o <= 1'b0;
    end else if (s2_en) begin
      res_valid_o <= s1_valid;
      res_id_o <= s1_id;
      res_sign_o <= s1_sign;
      res_zero_o <= zero;
      res_uflow_o <= ~zero & uflow;
      res_exp_o <= (zero | uflow) ? '0 : s1_exp - EW'(cnt);
      res_mant_o <= (zero | uflow) ? '0 : s1_mant << cnt;
    end
  end
endmodule
